// File: rtl/tty_pkg.sv
// Shared constants and types for the KL8E console printer: IOT op bits, device code, serializer states.
package tty_pkg;

    localparam int unsigned IOT_SKIP  = 0;
    localparam int unsigned IOT_CLR   = 1;
    localparam int unsigned IOT_PRINT = 2;

    localparam logic [5:0] DEV_TTO   = 6'o04;
    localparam logic [2:0] IOT_IE_OP = 3'b101;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tto_state_t;

    // Line level presented while the serializer sits in a given state.
    function automatic logic line_level(input tto_state_t st, input logic data_bit);
        case (st)
            START:   return 1'b0;
            DATA:    return data_bit;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 transmitter: start/ready handshake, per-state baud counter, LSB-first shift register.
module uart_tx_serializer
    import tty_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready_c,
    output logic       done_c,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tto_state_t       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;

    assign ready_c = (state == IDLE);

    // Next-state: every non-idle state lasts exactly CLKS_PER_BIT cycles.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = START;
                    cnt_n   = '0;
                    shift_n = data;
                end
            end
            START: begin
                if (cnt == CNT_LAST) begin
                    state_n   = DATA;
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shift_n   = {1'b0, shift[7:1]};
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    done_c  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Line and busy are registered from next-state so they track the state register exactly.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            busy    <= 1'b0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            busy    <= (state_n != IDLE);
            tx      <= line_level(state_n, shift_n[0]);
        end
    end

endmodule

// File: rtl/tty_printer_kl8e.sv
// KL8E printer half: IOT decode, printer flag, overrun, ack pipeline around an 8N1 serializer.
// Optional interrupt-enable register (IOT 6045) and irq output when TTY_IRQ_EN is defined.
module tty_printer_kl8e
    import tty_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned BAUD        = 115_200,
    parameter logic [5:0]  DEVICE_CODE = DEV_TTO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iot_valid,
    input  logic [5:0] iot_device,
    input  logic [2:0] iot_op,
    input  logic [7:0] ac_in,
    output logic       iot_ack,
    output logic       skip,
    output logic       irq,
    output logic       busy,
    output logic       overrun,
    output logic       uart_tx
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

    logic match_c, ie_op_c, print_req_c, start_c, ready_c, done_c;
    logic flag, flag_n, skip_n, overrun_n;

    // Decode; completion set takes priority over a coincident clear so no character-done is lost.
    always_comb begin
        match_c = iot_valid && (iot_device == DEVICE_CODE);
`ifdef TTY_IRQ_EN
        ie_op_c = (iot_op == IOT_IE_OP);
`else
        ie_op_c = 1'b0;
`endif
        print_req_c = match_c && !ie_op_c && iot_op[IOT_PRINT];
        start_c     = print_req_c && ready_c;
        overrun_n   = overrun || (print_req_c && !ready_c);
        skip_n      = match_c && !ie_op_c && iot_op[IOT_SKIP] && flag;
        flag_n      = flag;
        if (match_c && !ie_op_c && iot_op[IOT_CLR]) begin
            flag_n = 1'b0;
        end
        if (done_c) begin
            flag_n = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            iot_ack <= 1'b0;
            skip    <= 1'b0;
            flag    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            iot_ack <= match_c;
            skip    <= skip_n;
            flag    <= flag_n;
            overrun <= overrun_n;
        end
    end

`ifdef TTY_IRQ_EN
    logic ie, ie_n;

    always_comb begin
        ie_n = ie;
        if (match_c && ie_op_c) begin
            ie_n = ac_in[0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ie  <= 1'b1;
            irq <= 1'b0;
        end else begin
            ie  <= ie_n;
            irq <= flag_n && ie_n;
        end
    end
`else
    assign irq = 1'b0;
`endif

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_ser (
        .clock  (clock),
        .reset  (reset),
        .start  (start_c),
        .data   (ac_in),
        .ready_c(ready_c),
        .done_c (done_c),
        .busy   (busy),
        .tx     (uart_tx)
    );

endmodule
